// File: rtl/serial_pkg.sv
// serial_pkg: shared types, constants and the CRC-4 step function for the
// ALU serial command receiver. The bench model imports the same package.
package serial_pkg;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_DATA = 2'd1,
    ERR_CRC  = 2'd2
  } err_t;

  localparam int   PKT_BITS  = 11;
  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CMD  = 1'b1;

  // x^4 + x + 1, with the x^4 term implicit
  localparam logic [3:0] crc4_poly = 4'h3;

  // One bit of a left-shifting CRC-4 LFSR (feedback = msb ^ incoming bit)
  function automatic logic [3:0] crc4_next(input logic [3:0] crc, input logic b);
    logic fb;
    fb = crc[3] ^ b;
    return {crc[2:0], 1'b0} ^ (fb ? crc4_poly : 4'h0);
  endfunction

endpackage

// File: rtl/serial_crc4.sv
// serial_crc4: bit-serial CRC-4 accumulator.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en, din    : shift din into the CRC when en is high
//   crc        : current remainder
module serial_crc4 import serial_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [3:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= '0;
    else if (clr) crc <= '0;
    else if (en)  crc <= crc4_next(crc, din);
  end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: deserialises 11-bit packets from sin, assembles a frame of
// NPKT data packets plus one command packet, checks framing and CRC-4 and
// presents the result on a valid/ready output register.
//   clk, rst_n  : clock, async active-low reset
//   sin         : serial input, idle high, one bit per clk
//   o_data      : operands, first received in the MSBs
//   o_op        : opcode from the command packet
//   o_err       : ERR_NONE / ERR_DATA / ERR_CRC
//   o_valid     : result held; i_ready accepts it
//   o_overflow  : one-cycle pulse when a completed frame was dropped
//   o_busy      : frame in progress
module serial_frame_rx import serial_pkg::*; #(
  parameter int OPERAND_W  = 32,
  parameter int N_OPERANDS = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sin,
  output logic [N_OPERANDS*OPERAND_W-1:0] o_data,
  output logic [2:0]                      o_op,
  output err_t                            o_err,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_overflow,
  output logic                            o_busy
);

  localparam int DW   = N_OPERANDS * OPERAND_W;
  localparam int NPKT = DW / 8;
  localparam int PW   = $clog2(NPKT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PKT    = 2'd1;
  localparam logic [1:0] S_RESYNC = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state;
  logic [3:0]    bcnt;      // bit index within the packet, 1..PKT_BITS-1
  logic [PW-1:0] pcnt;      // data packets received in this frame
  logic          ptype;
  logic [7:0]    sh;        // payload shifter
  logic [DW-1:0] dsr;       // accumulated operand bytes
  logic          fin_q;     // frame completed last edge; load next edge
  err_t          fin_err;
  logic [2:0]    fin_op;
  logic [3:0]    crc;
  logic          crc_clr;
  logic          crc_en;
  logic          load;

  // A start bit seen while not busy opens a new frame.
  assign crc_clr = (state == S_IDLE) && !sin && !o_busy;

  // CRC covers data payload bits, then the command type bit (always 1),
  // then the three opcode bits. Bit 1 is fed before ptype is registered.
  always_comb begin
    crc_en = 1'b0;
    if (state == S_PKT) begin
      if (bcnt == 4'd1)            crc_en = sin;
      else if (ptype == TYPE_DATA) crc_en = (bcnt >= 4'd2) && (bcnt <= 4'd9);
      else                         crc_en = (bcnt >= 4'd3) && (bcnt <= 4'd5);
    end
  end

  serial_crc4 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (sin),
    .crc   (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bcnt    <= '0;
      pcnt    <= '0;
      ptype   <= 1'b0;
      sh      <= '0;
      dsr     <= '0;
      fin_q   <= 1'b0;
      fin_err <= ERR_NONE;
      fin_op  <= '0;
      o_busy  <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!sin) begin
            state  <= S_PKT;
            bcnt   <= 4'd1;
            o_busy <= 1'b1;
            if (!o_busy) begin
              dsr  <= '0;
              pcnt <= '0;
            end
          end
        end
        S_PKT: begin
          bcnt <= bcnt + 4'd1;
          if (bcnt == 4'd1) begin
            ptype <= sin;
          end else if (bcnt <= 4'd9) begin
            sh <= {sh[6:0], sin};
          end else begin
            // stop bit
            bcnt <= '0;
            if (!sin) begin
              state   <= S_RESYNC;
              fin_q   <= 1'b1;
              fin_err <= ERR_DATA;
              fin_op  <= '0;
              o_busy  <= 1'b0;
              pcnt    <= '0;
            end else if (ptype == TYPE_DATA && pcnt < PW'(NPKT)) begin
              dsr   <= (dsr << 8) | DW'(sh);
              pcnt  <= pcnt + 1'b1;
              state <= S_IDLE;
            end else begin
              state  <= S_DONE;
              fin_q  <= 1'b1;
              o_busy <= 1'b0;
              pcnt   <= '0;
              if (ptype == TYPE_CMD && pcnt == PW'(NPKT)) begin
                fin_op  <= sh[6:4];
                fin_err <= (sh[3:0] == crc) ? ERR_NONE : ERR_CRC;
              end else begin
                fin_op  <= '0;
                fin_err <= ERR_DATA;
              end
            end
          end
        end
        S_RESYNC: if (sin) state <= S_IDLE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Load only into an empty register or one being drained this same edge.
  assign load = fin_q && (!o_valid || i_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data     <= '0;
      o_op       <= '0;
      o_err      <= ERR_NONE;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= fin_q && !load;
      if (load) begin
        o_valid <= 1'b1;
        o_err   <= fin_err;
        if (fin_err == ERR_DATA) begin
          o_data <= '0;
          o_op   <= '0;
        end else begin
          o_data <= dsr;
          o_op   <= fin_op;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
